// File: rtl/mat_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one 4x4 fixed-point mat_mul unit among NUM_REQ
// requesters: clears the unit, issues operands, waits with a watchdog, returns tagged product.
module mat_mul_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned TIMEOUT   = 32
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_REQ-1:0]                          req_valid,
  input  logic [NUM_REQ-1:0][3:0][3:0][DATAWIDTH-1:0] req_A,
  input  logic [NUM_REQ-1:0][3:0][3:0][DATAWIDTH-1:0] req_B,
  output logic [NUM_REQ-1:0]                          req_ready,
  output logic [3:0][3:0][DATAWIDTH-1:0]              resp_C,
  output logic                                        resp_dv,
  output logic [$clog2(NUM_REQ)-1:0]                  resp_id,
  output logic                                        err,
  output logic                                        busy,
  output logic                                        mm_rstn,
  output logic [3:0][3:0][DATAWIDTH-1:0]              mm_A,
  output logic [3:0][3:0][DATAWIDTH-1:0]              mm_B,
  output logic                                        mm_i_dv,
  input  logic [3:0][3:0][DATAWIDTH-1:0]              mm_C,
  input  logic                                        mm_o_dv,
  input  logic                                        mm_o_ready
);
  localparam int unsigned IdW = $clog2(NUM_REQ);
  localparam int unsigned TmW = $clog2(TIMEOUT);

  typedef logic [3:0][3:0][DATAWIDTH-1:0] mat_t;
  typedef enum logic [1:0] {StIdle, StClear, StIssue, StWait} state_e;

  state_e         state_q, state_d;
  logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0] grant_id_q, grant_id_d;
  logic [IdW-1:0] resp_id_q, resp_id_d;
  logic [TmW-1:0] timer_q, timer_d;
  mat_t           mm_a_q, mm_a_d, mm_b_q, mm_b_d, resp_c_q, resp_c_d;
  logic           mm_rstn_q, mm_rstn_d;
  logic           mm_i_dv_q, mm_i_dv_d;
  logic           resp_dv_q, resp_dv_d;
  logic           err_q, err_d;
  logic           found;
  logic [IdW-1:0] cand, pick;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IdW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Gated by rst so nothing is offered while the block is held in reset.
  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && !rst && mm_o_ready && found) begin
      req_ready[pick] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    timer_d    = timer_q;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;
    mm_rstn_d  = 1'b1;
    mm_i_dv_d  = 1'b0;
    resp_c_d   = resp_c_q;
    resp_id_d  = resp_id_q;
    resp_dv_d  = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (|req_ready) begin
          mm_a_d     = req_A[pick];
          mm_b_d     = req_B[pick];
          grant_id_d = pick;
          rr_ptr_d   = IdW'((32'(pick) + 32'd1) % NUM_REQ);
          mm_rstn_d  = 1'b0;
          state_d    = StClear;
        end
      end
      StClear: state_d = StIssue;
      StIssue: begin
        mm_i_dv_d = 1'b1;
        timer_d   = '0;
        state_d   = StWait;
      end
      StWait: begin
        timer_d = timer_q + TmW'(1);
        // A result arriving on the timeout cycle still counts as a completion.
        if (mm_o_dv) begin
          resp_c_d  = mm_C;
          resp_id_d = grant_id_q;
          resp_dv_d = 1'b1;
          state_d   = StIdle;
        end else if (timer_q == TmW'(TIMEOUT - 1)) begin
          err_d     = 1'b1;
          mm_rstn_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      timer_q    <= '0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_rstn_q  <= 1'b0;
      mm_i_dv_q  <= 1'b0;
      resp_c_q   <= '0;
      resp_id_q  <= '0;
      resp_dv_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      timer_q    <= timer_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
      mm_rstn_q  <= mm_rstn_d;
      mm_i_dv_q  <= mm_i_dv_d;
      resp_c_q   <= resp_c_d;
      resp_id_q  <= resp_id_d;
      resp_dv_q  <= resp_dv_d;
      err_q      <= err_d;
    end
  end

  assign resp_C  = resp_c_q;
  assign resp_id = resp_id_q;
  assign resp_dv = resp_dv_q;
  assign err     = err_q;
  assign busy    = (state_q != StIdle);
  assign mm_rstn = mm_rstn_q;
  assign mm_A    = mm_a_q;
  assign mm_B    = mm_b_q;
  assign mm_i_dv = mm_i_dv_q;

endmodule

// File: tb/tb_mat_mul_arbiter.sv
// Bench for mat_mul_arbiter: behavioural accumulating mat_mul stub plus a round-robin /
// fixed-point product reference model, driven by directed and $urandom traffic.
module tb_mat_mul_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 32;
  localparam int unsigned IW = $clog2(N);

  typedef logic [3:0][3:0][DW-1:0] mat_t;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [N-1:0]                 req_valid;
  logic [N-1:0][3:0][3:0][DW-1:0] req_A, req_B;
  logic [N-1:0]                 req_ready;
  mat_t                         resp_C;
  logic                         resp_dv;
  logic [IW-1:0]                resp_id;
  logic                         err, busy, mm_rstn, mm_i_dv;
  mat_t                         mm_A, mm_B, mm_C;
  logic                         mm_o_dv, mm_ready;

  int checks = 0;
  int failures = 0;

  // Stub state
  mat_t acc = '0;
  mat_t stub_c = '0;
  mat_t late_c = '0;
  int   cnt = 0;
  int   stub_lat = 3;
  logic stub_en = 1'b1;
  logic stub_dv = 1'b0;
  logic late_dv = 1'b0;

  always #5 clk = ~clk;

  mat_mul_arbiter #(.NUM_REQ(N), .DATAWIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_A(req_A), .req_B(req_B),
    .req_ready(req_ready), .resp_C(resp_C), .resp_dv(resp_dv), .resp_id(resp_id),
    .err(err), .busy(busy), .mm_rstn(mm_rstn), .mm_A(mm_A), .mm_B(mm_B),
    .mm_i_dv(mm_i_dv), .mm_C(mm_C), .mm_o_dv(mm_o_dv), .mm_o_ready(mm_ready)
  );

  assign mm_o_dv = stub_dv | late_dv;
  assign mm_C    = late_dv ? late_c : stub_c;

  // Q8.8 product: 64-bit exact sum, arithmetic shift, truncate to element width.
  function automatic mat_t mat_mul_ref(input mat_t a, input mat_t b);
    mat_t   c;
    longint s;
    c = '0;
    for (int r = 0; r < 4; r++) begin
      for (int col = 0; col < 4; col++) begin
        s = 0;
        for (int k = 0; k < 4; k++) begin
          s += longint'($signed(a[r][k])) * longint'($signed(b[k][col]));
        end
        c[r][col] = DW'(s >>> 8);
      end
    end
    return c;
  endfunction

  function automatic mat_t mat_add(input mat_t a, input mat_t b);
    mat_t c;
    for (int r = 0; r < 4; r++)
      for (int col = 0; col < 4; col++) c[r][col] = a[r][col] + b[r][col];
    return c;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int r = 0; r < 4; r++)
      for (int col = 0; col < 4; col++) m[r][col] = DW'($urandom);
    return m;
  endfunction

  // mat_mul stub: accumulates every issued product until its rstn is pulled low.
  always @(posedge clk) begin
    #1;
    stub_dv = 1'b0;
    if (!mm_rstn) begin
      acc = '0;
      cnt = 0;
    end else if (mm_i_dv) begin
      acc = mat_add(acc, mat_mul_ref(mm_A, mm_B));
      cnt = stub_lat;
    end else if (cnt != 0) begin
      cnt--;
      if (cnt == 0 && stub_en) begin
        stub_dv = 1'b1;
        stub_c  = acc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0; late_dv = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; mm_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++; if (resp_dv !== 1'b0) begin failures++; $display("FAIL reset_resp_dv got=%b exp=0", resp_dv); end
    checks++; if (mm_rstn !== 1'b0) begin failures++; $display("FAIL reset_mm_rstn got=%b exp=0", mm_rstn); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (resp_C !== '0 || resp_id !== '0 || err !== 1'b0 || mm_i_dv !== 1'b0)
      begin failures++; $display("FAIL reset_outputs resp_C=%h resp_id=%0d err=%b mm_i_dv=%b exp=zero", resp_C, resp_id, err, mm_i_dv); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL release_req_ready got=%b exp=0001", req_ready); end
    req_valid = '0;
    @(negedge clk);
    checks++; if (mm_rstn !== 1'b1) begin failures++; $display("FAIL release_mm_rstn got=%b exp=1", mm_rstn); end
  endtask

  task automatic test_single();
    mat_t a, b, exp_c;
    int   rstn_lo, rstn_cyc, idv, idv_cyc, dv;
    do_reset();
    a = '0; b = '0; exp_c = '0;
    for (int r = 0; r < 4; r++) begin
      a[r][r] = 16'h0100; b[r][r] = 16'h0200; exp_c[r][r] = 16'h0200;
    end
    stub_lat = 3; mm_ready = 1'b0;
    req_A[2] = a; req_B[2] = b; req_valid = 4'b0100;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL not_ready_gate got=%b exp=0000", req_ready); end
    mm_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b exp=0100", req_ready); end
    rstn_lo = 0; rstn_cyc = -1; idv = 0; idv_cyc = -1; dv = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) req_valid = '0;
      @(negedge clk);
      if (!mm_rstn) begin rstn_lo++; if (rstn_cyc < 0) rstn_cyc = cyc; end
      if (mm_i_dv) begin idv++; if (idv_cyc < 0) idv_cyc = cyc; end
      if (resp_dv) begin
        dv++;
        checks++; if (resp_C !== exp_c) begin failures++; $display("FAIL single_resp_C got=%h exp=%h", resp_C, exp_c); end
        checks++; if (resp_id !== IW'(2)) begin failures++; $display("FAIL single_resp_id got=%0d exp=2", resp_id); end
      end
    end
    checks++; if (rstn_lo != 1 || rstn_cyc != 0) begin failures++; $display("FAIL single_clear got_low=%0d at=%0d exp=1 at 0", rstn_lo, rstn_cyc); end
    checks++; if (idv != 1 || idv_cyc != 2) begin failures++; $display("FAIL single_issue got_pulses=%0d at=%0d exp=1 at 2", idv, idv_cyc); end
    checks++; if (dv != 1) begin failures++; $display("FAIL single_resp_dv_count got=%0d exp=1", dv); end
    checks++; if (resp_C !== exp_c) begin failures++; $display("FAIL single_hold got=%h exp=%h", resp_C, exp_c); end
  endtask

  task automatic test_round_robin();
    mat_t oa [N];
    mat_t ob [N];
    int   order [5];
    int   q [$];
    int   grants, resps, g;
    do_reset();
    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) begin
      oa[i] = rand_mat(); ob[i] = rand_mat();
      req_A[i] = oa[i]; req_B[i] = ob[i];
    end
    stub_lat = 2; req_valid = '1;
    grants = 0; resps = 0;
    for (int cyc = 0; cyc < 400 && resps < 5; cyc++) begin
      @(negedge clk);
      if (resp_dv) begin
        checks++;
        if (q.size() == 0) begin failures++; $display("FAIL rr_unexpected_resp id=%0d", resp_id); end
        else begin
          if (resp_id !== IW'(q[0]) || resp_C !== mat_mul_ref(oa[q[0]], ob[q[0]])) begin
            failures++; $display("FAIL rr_resp got_id=%0d exp_id=%0d got_C=%h exp_C=%h", resp_id, q[0], resp_C, mat_mul_ref(oa[q[0]], ob[q[0]]));
          end
          void'(q.pop_front());
        end
        resps++;
      end
      if (|req_ready) begin
        g = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        checks++;
        if (grants >= 5 || g != order[grants]) begin
          failures++; $display("FAIL rr_order grant#%0d got=%0d exp=%0d", grants, g, (grants < 5) ? order[grants] : -1);
        end
        q.push_back(g);
        grants++;
      end
      @(posedge clk); #1;
      if (grants >= 5) req_valid = '0;
    end
    checks++; if (resps != 5) begin failures++; $display("FAIL rr_completions got=%0d exp=5", resps); end
  endtask

  task automatic test_back_to_back();
    mat_t a, b, exp_c;
    int   grants, resps;
    do_reset();
    a = rand_mat(); b = rand_mat(); exp_c = mat_mul_ref(a, b);
    stub_lat = int'($urandom_range(1, 6));
    req_A[1] = a; req_B[1] = b; req_valid = 4'b0010;
    grants = 0; resps = 0;
    for (int cyc = 0; cyc < 200 && resps < 2; cyc++) begin
      @(negedge clk);
      if (resp_dv) begin
        resps++;
        checks++; if (resp_C !== exp_c || resp_id !== IW'(1)) begin failures++; $display("FAIL b2b_result#%0d got=%h id=%0d exp=%h id=1", resps, resp_C, resp_id, exp_c); end
        if (resps == 1) begin
          checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL b2b_accept_with_resp got=%b exp=0010", req_ready); end
        end
      end
      if (|req_ready) grants++;
      @(posedge clk); #1;
      if (grants >= 2) req_valid = '0;
    end
    checks++; if (resps != 2) begin failures++; $display("FAIL b2b_completions got=%0d exp=2", resps); end
  endtask

  task automatic test_random();
    mat_t oa [N];
    mat_t ob [N];
    mat_t qc [$];
    int   qi [$];
    int   others [N];
    logic [N-1:0] exp_ready;
    int   m_ptr, expi, gidx, grants, resps, idx;
    do_reset();
    m_ptr = 0; grants = 0; resps = 0;
    for (int i = 0; i < N; i++) others[i] = 0;
    for (int cyc = 0; cyc < 3000 && !(grants >= 30 && resps == grants); cyc++) begin
      @(negedge clk);
      gidx = -1;
      checks++; if (resp_dv && err) begin failures++; $display("FAIL rnd_dv_and_err both high"); end
      expi = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (req_valid[idx] && expi < 0) expi = idx;
      end
      exp_ready = (busy || !mm_ready || expi < 0) ? '0 : N'(1) << expi;
      checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready); end
      if (resp_dv) begin
        checks++;
        if (qi.size() == 0) begin failures++; $display("FAIL rnd_unexpected_resp id=%0d", resp_id); end
        else begin
          if (resp_id !== IW'(qi[0]) || resp_C !== qc[0]) begin
            failures++; $display("FAIL rnd_resp got_id=%0d exp_id=%0d got_C=%h exp_C=%h", resp_id, qi[0], resp_C, qc[0]);
          end
          void'(qi.pop_front()); void'(qc.pop_front());
        end
        resps++;
      end
      if (exp_ready != '0) begin
        gidx = expi;
        checks++; if (others[gidx] > N - 1) begin failures++; $display("FAIL rnd_starvation req=%0d waited=%0d max=%0d", gidx, others[gidx], N - 1); end
        for (int i = 0; i < N; i++) if (i != gidx && req_valid[i]) others[i]++;
        others[gidx] = 0;
        qi.push_back(gidx); qc.push_back(mat_mul_ref(oa[gidx], ob[gidx]));
        m_ptr = (gidx + 1) % N;
        grants++;
      end
      @(posedge clk); #1;
      if (gidx >= 0) req_valid[gidx] = 1'b0;
      mm_ready = ($urandom_range(0, 4) != 0);
      stub_lat = int'($urandom_range(1, 8));
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && grants < 30 && $urandom_range(0, 3) == 0) begin
          oa[i] = rand_mat(); ob[i] = rand_mat();
          req_A[i] = oa[i]; req_B[i] = ob[i]; req_valid[i] = 1'b1;
        end
      end
    end
    checks++; if (grants < 30 || resps != grants) begin failures++; $display("FAIL rnd_completions grants=%0d resps=%0d exp>=30 equal", grants, resps); end
    req_valid = '0; mm_ready = 1'b1;
  endtask

  task automatic test_watchdog();
    int  k, dvs;
    bit  got;
    do_reset();
    stub_en = 1'b0; req_A[3] = rand_mat(); req_B[3] = rand_mat(); req_valid = 4'b1000;
    got = 0;
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      @(negedge clk);
      if (mm_i_dv) got = 1;
      else begin @(posedge clk); #1; if (busy) req_valid = '0; end
    end
    checks++; if (!got) begin failures++; $display("FAIL wd_issue got=none exp=mm_i_dv pulse"); end
    k = 0; dvs = 0; got = 0;
    while (k < TO + 10 && !got) begin
      @(negedge clk);
      k++;
      if (resp_dv) dvs++;
      if (err) got = 1;
    end
    checks++; if (!got || k != TO) begin failures++; $display("FAIL wd_err_delay got=%0d exp=%0d", got ? k : -1, TO); end
    checks++; if (dvs != 0) begin failures++; $display("FAIL wd_resp_dv got=%0d exp=0", dvs); end
    checks++; if (busy !== 1'b0 || mm_rstn !== 1'b0) begin failures++; $display("FAIL wd_abort busy=%b mm_rstn=%b exp=0 0", busy, mm_rstn); end
    @(negedge clk);
    checks++; if (err !== 1'b0 || mm_rstn !== 1'b1 || resp_dv !== 1'b0) begin failures++; $display("FAIL wd_after err=%b mm_rstn=%b resp_dv=%b exp=0 1 0", err, mm_rstn, resp_dv); end
    stub_en = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    int  dvs;
    bit  got;
    // A completed request first, so the reset has a non-zero result to clear.
    stub_en = 1'b1; stub_lat = 2;
    req_A[0] = rand_mat(); req_B[0] = rand_mat(); req_A[0][0][0] = 16'h0100; req_B[0][0][0] = 16'h7fff;
    req_valid = 4'b0001; got = 0;
    for (int cyc = 0; cyc < 60 && !got; cyc++) begin
      @(negedge clk);
      if (resp_dv) got = 1;
      @(posedge clk); #1;
      if (busy) req_valid = '0;
    end
    checks++; if (!got) begin failures++; $display("FAIL mid_first_resp got=none exp=resp_dv"); end
    stub_en = 1'b0; req_valid = 4'b0001; got = 0;
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      @(negedge clk);
      if (mm_i_dv) got = 1;
      else begin @(posedge clk); #1; if (busy) req_valid = '0; end
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || resp_dv !== 1'b0 || err !== 1'b0 || mm_rstn !== 1'b0 || mm_i_dv !== 1'b0)
      begin failures++; $display("FAIL mid_reset_ctrl busy=%b dv=%b err=%b mm_rstn=%b i_dv=%b exp=0", busy, resp_dv, err, mm_rstn, mm_i_dv); end
    checks++; if (resp_C !== '0 || resp_id !== '0 || mm_A !== '0 || mm_B !== '0)
      begin failures++; $display("FAIL mid_reset_data resp_C=%h resp_id=%0d mm_A=%h exp=0", resp_C, resp_id, mm_A); end
    @(posedge clk); #1;
    late_c = rand_mat(); late_dv = 1'b1;
    @(posedge clk); #1 late_dv = 1'b0;
    dvs = 0;
    repeat (6) begin @(negedge clk); if (resp_dv) dvs++; end
    checks++; if (dvs != 0 || resp_C !== '0) begin failures++; $display("FAIL mid_late_dv resp_dv_count=%0d resp_C=%h exp=0 0", dvs, resp_C); end
    stub_en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_A = '0; req_B = '0; mm_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_random();
    test_watchdog();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
